// File: rtl/hba_qtr_array_pkg.sv
// rtl/hba_qtr_array_pkg.sv - shared types and constants for the QTR sensor array peripheral
package hba_qtr_array_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHARGE,
        MEASURE,
        DONE
    } chan_state_t;

    localparam int REG_CTRL     = 0;
    localparam int REG_MASK     = 1;
    localparam int REG_PERIOD   = 2;
    localparam int REG_THRESH   = 3;
    localparam int REG_STATUS   = 4;
    localparam int REG_LINE     = 5;
    localparam int REG_VAL_BASE = 8;

    localparam int CTRL_RUN     = 0;
    localparam int CTRL_INTR_EN = 1;
    localparam int CTRL_TRIGGER = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_OVERRUN = 2;

    localparam int PERIOD_RESET = 50;

endpackage

// File: rtl/qtr_chan.sv
// rtl/qtr_chan.sv - one QTR channel: input synchroniser plus charge/measure FSM
module qtr_chan
    import hba_qtr_array_pkg::*;
#(
    parameter int VALUE_WIDTH   = 8,
    parameter int CHARGE_CYCLES = 600
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   ack,
    input  logic                   tick,
    input  logic                   in_sig,
    output logic                   done,
    output logic [VALUE_WIDTH-1:0] value,
    output logic                   out_en,
    output logic                   out_sig,
    output logic                   ctrl
);
    localparam int CW = (CHARGE_CYCLES > 1) ? $clog2(CHARGE_CYCLES) : 1;
    localparam logic [VALUE_WIDTH-1:0] VMAX = '1;

    chan_state_t            state, state_nx;
    logic [1:0]             sync_ff;
    logic [CW-1:0]          charge_cnt;
    logic [VALUE_WIDTH-1:0] count;
    logic                   in_low, charge_end, meas_end;

    assign in_low     = ~sync_ff[1];
    assign charge_end = (charge_cnt == CW'(CHARGE_CYCLES - 1));
    assign meas_end   = in_low || (count == VMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)      state_nx = CHARGE;
            CHARGE:  if (charge_end) state_nx = MEASURE;
            MEASURE: if (meas_end)   state_nx = DONE;
            DONE:    if (ack)        state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    // count holds the number of ticks seen since MEASURE was entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff    <= 2'b11;
            charge_cnt <= '0;
            count      <= '0;
            value      <= '0;
        end else begin
            sync_ff    <= {sync_ff[0], in_sig};
            charge_cnt <= (state == CHARGE) ? charge_cnt + CW'(1) : '0;
            if (state != MEASURE)      count <= '0;
            else if (!meas_end && tick) count <= count + VALUE_WIDTH'(1);
            if (state == MEASURE && meas_end) value <= count;
        end
    end

    always_comb begin
        out_en  = (state == CHARGE);
        out_sig = (state == CHARGE);
        ctrl    = (state == CHARGE) || (state == MEASURE);
        done    = (state == DONE);
    end

endmodule

// File: rtl/hba_qtr_array.sv
// rtl/hba_qtr_array.sv - HBA QTR reflectance array scanner; define QTR_AVG_EN for 4-sample averaging
module hba_qtr_array
    import hba_qtr_array_pkg::*;
#(
    parameter int CLK_FREQUENCY     = 60_000_000,
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
    parameter int PERIPH_ADDR       = 0,
    parameter int NUM_CH            = 8,
    parameter int VALUE_WIDTH       = 8,
    parameter int TICK_US           = 10,
    parameter int CHARGE_US         = 10
) (
    input  logic                  hba_clk,
    input  logic                  hba_reset_n,
    input  logic                  hba_rnw,
    input  logic                  hba_select,
    input  logic [ADDR_WIDTH-1:0] hba_abus,
    input  logic [DBUS_WIDTH-1:0] hba_dbus,
    output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
    output logic                  hba_xferack_slave,
    output logic                  slave_interrupt,
    output logic [NUM_CH-1:0]     qtr_out_en,
    output logic [NUM_CH-1:0]     qtr_out_sig,
    input  logic [NUM_CH-1:0]     qtr_in_sig,
    output logic [NUM_CH-1:0]     qtr_ctrl
);
    localparam int TICK_CYCLES   = int'(longint'(CLK_FREQUENCY) * TICK_US / 1_000_000);
    localparam int CHARGE_CYCLES = int'(longint'(CLK_FREQUENCY) * CHARGE_US / 1_000_000);
    localparam int TICKS_PER_MS  = 1000 / TICK_US;
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int SW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

    logic                   run, intr_en, trig_q, busy, done, overrun, seen;
    logic                   tick, ms_tick, sync, match, xfer, wr, rd, status_rd, req, scan_go, finish;
    logic [NUM_CH-1:0]      mask, scan_mask, line, new_line, start_vec, ack_vec, chan_done;
    logic [DBUS_WIDTH-1:0]  period, thresh, per_eff, ms_cnt, rdata;
    logic [PW-1:0]          pre_cnt;
    logic [SW-1:0]          sub_cnt;
    logic [31:0]            radr;
    logic [VALUE_WIDTH-1:0] val [NUM_CH];
    logic [VALUE_WIDTH-1:0] chan_value [NUM_CH];
    logic [VALUE_WIDTH-1:0] new_val [NUM_CH];

    assign tick    = (pre_cnt == PW'(TICK_CYCLES - 1));
    assign ms_tick = tick && (sub_cnt == SW'(TICKS_PER_MS - 1));
    assign per_eff = (period == '0) ? DBUS_WIDTH'(1) : period;
    assign sync    = run && ms_tick && (ms_cnt >= per_eff - DBUS_WIDTH'(1));

    // the ms counters are held at zero while stopped so run 0->1 restarts the period
    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            pre_cnt <= '0;
            sub_cnt <= '0;
            ms_cnt  <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            if (!run) begin
                sub_cnt <= '0;
                ms_cnt  <= '0;
            end else if (tick) begin
                sub_cnt <= ms_tick ? '0 : sub_cnt + SW'(1);
                if (ms_tick) ms_cnt <= (ms_cnt >= per_eff - DBUS_WIDTH'(1)) ? '0 : ms_cnt + DBUS_WIDTH'(1);
            end
        end
    end

    assign match     = hba_select && (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));
    assign xfer      = match && !seen;
    assign wr        = xfer && !hba_rnw;
    assign rd        = xfer && hba_rnw;
    assign radr      = 32'(hba_abus[REG_ADDR_WIDTH-1:0]);
    assign status_rd = rd && (radr == REG_STATUS);

    always_comb begin
        rdata = '0;
        case (radr)
            REG_CTRL:   rdata = DBUS_WIDTH'({intr_en, run});
            REG_MASK:   rdata = DBUS_WIDTH'(mask);
            REG_PERIOD: rdata = period;
            REG_THRESH: rdata = thresh;
            REG_STATUS: rdata = DBUS_WIDTH'({overrun, done, busy});
            REG_LINE:   rdata = DBUS_WIDTH'(line);
            default:
                for (int i = 0; i < NUM_CH; i++)
                    if (radr == 32'(REG_VAL_BASE + i)) rdata = DBUS_WIDTH'(val[i]);
        endcase
    end

    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            run               <= 1'b0;
            intr_en           <= 1'b0;
            trig_q            <= 1'b0;
            mask              <= '0;
            period            <= DBUS_WIDTH'(PERIOD_RESET);
            thresh            <= '0;
            seen              <= 1'b0;
            hba_xferack_slave <= 1'b0;
            hba_dbus_slave    <= '0;
        end else begin
            seen              <= match;
            hba_xferack_slave <= xfer;
            hba_dbus_slave    <= rd ? rdata : '0;
            trig_q            <= wr && (radr == REG_CTRL) && hba_dbus[CTRL_TRIGGER];
            if (wr) begin
                case (radr)
                    REG_CTRL: begin
                        run     <= hba_dbus[CTRL_RUN];
                        intr_en <= hba_dbus[CTRL_INTR_EN];
                    end
                    REG_MASK:   mask   <= hba_dbus[NUM_CH-1:0];
                    REG_PERIOD: period <= hba_dbus;
                    REG_THRESH: thresh <= hba_dbus;
                    default: ;
                endcase
            end
        end
    end

    assign req       = sync || trig_q;
    assign scan_go   = req && (mask != '0) && !busy;
    assign finish    = busy && (&(chan_done | ~scan_mask));
    assign start_vec = scan_go ? mask : '0;
    assign ack_vec   = finish ? scan_mask : '0;

    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            busy      <= 1'b0;
            scan_mask <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (scan_go) begin
                busy      <= 1'b1;
                scan_mask <= mask;
            end else if (finish) begin
                busy <= 1'b0;
            end
            if (status_rd) begin
                done    <= 1'b0;
                overrun <= 1'b0;
            end
            if (finish)       done    <= 1'b1;
            if (req && busy)  overrun <= 1'b1;
        end
    end

    assign slave_interrupt = done && intr_en;

`ifdef QTR_AVG_EN
    logic [VALUE_WIDTH-1:0] hist [NUM_CH][3];
    logic [VALUE_WIDTH+1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc = (VALUE_WIDTH+2)'(hist[i][0]) + (VALUE_WIDTH+2)'(hist[i][1])
                + (VALUE_WIDTH+2)'(hist[i][2]) + (VALUE_WIDTH+2)'(chan_value[i]);
            new_val[i] = acc[VALUE_WIDTH+1:2];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) new_val[i] = chan_value[i];
    end
`endif

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            new_line[i] = DBUS_WIDTH'(scan_mask[i] ? new_val[i] : val[i]) >= thresh;
    end

    // disabled channels keep their previous snapshot across a scan
    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            line <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                val[i] <= '0;
`ifdef QTR_AVG_EN
                for (int j = 0; j < 3; j++) hist[i][j] <= '0;
`endif
            end
        end else if (finish) begin
            line <= new_line;
            for (int i = 0; i < NUM_CH; i++) begin
                if (scan_mask[i]) begin
                    val[i] <= new_val[i];
`ifdef QTR_AVG_EN
                    hist[i][2] <= hist[i][1];
                    hist[i][1] <= hist[i][0];
                    hist[i][0] <= chan_value[i];
`endif
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        qtr_chan #(
            .VALUE_WIDTH   (VALUE_WIDTH),
            .CHARGE_CYCLES (CHARGE_CYCLES)
        ) u_chan (
            .clk     (hba_clk),
            .rst_n   (hba_reset_n),
            .start   (start_vec[g]),
            .ack     (ack_vec[g]),
            .tick    (tick),
            .in_sig  (qtr_in_sig[g]),
            .done    (chan_done[g]),
            .value   (chan_value[g]),
            .out_en  (qtr_out_en[g]),
            .out_sig (qtr_out_sig[g]),
            .ctrl    (qtr_ctrl[g])
        );
    end

endmodule

// File: tb/tb_hba_qtr_array.sv
// tb/tb_hba_qtr_array.sv - randomized self-checking bench for hba_qtr_array
module tb_hba_qtr_array;
    localparam int T = 10;

    logic        clk = 1'b0, rst_n = 1'b0, rnw = 1'b0, sel = 1'b0;
    logic [11:0] abus = '0;
    logic [7:0]  dbus = '0, qin = '1;
    logic [7:0]  dslv, oen, osig, qctrl;
    logic        ack, irq;

    int n_tests = 0, n_fail = 0, n_starts = 0, cyc = 0;
    int start_times[$];
    int dly[8];
    logic [7:0] m_val[8];
    logic [7:0] m_mask = '0, m_thresh = '0, m_line = '0;
    int m_hist[8][4];
    logic ack_prev = 1'b0;
    logic [7:0] prev_oen = '0;

    always #5 clk = ~clk;

    hba_qtr_array #(
        .CLK_FREQUENCY(1_000_000), .DBUS_WIDTH(8), .PERIPH_ADDR_WIDTH(4), .REG_ADDR_WIDTH(8),
        .ADDR_WIDTH(12), .PERIPH_ADDR(0), .NUM_CH(8), .VALUE_WIDTH(8), .TICK_US(10), .CHARGE_US(10)
    ) dut (
        .hba_clk(clk), .hba_reset_n(rst_n), .hba_rnw(rnw), .hba_select(sel), .hba_abus(abus),
        .hba_dbus(dbus), .hba_dbus_slave(dslv), .hba_xferack_slave(ack), .slave_interrupt(irq),
        .qtr_out_en(oen), .qtr_out_sig(osig), .qtr_in_sig(qin), .qtr_ctrl(qctrl)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // per-cycle protocol and pad checks against the bench's view of the configuration
    always @(negedge clk) begin
        if (rst_n) begin
            if (!ack) check("dbus_idle", dslv, 0);
            if (ack_prev) check("ack_single", ack, 0);
            check("pad_sig", osig, oen);
            check("pad_mask", oen & ~m_mask, 0);
            check("pad_ctrl", oen & ~qctrl, 0);
            if (oen != 0 && prev_oen == 0) begin
                n_starts++;
                start_times.push_back(cyc);
            end
        end
        ack_prev = ack;
        prev_oen = oen;
    end

    task automatic bus(input bit is_rd, input int addr, input logic [7:0] wdata, output logic [7:0] rdata);
        bit got = 0;
        @(negedge clk);
        sel = 1'b1; rnw = is_rd; abus = 12'(addr); dbus = wdata;
        rdata = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) begin rdata = dslv; got = 1; break; end
        end
        sel = 1'b0;
        check("xfer_ack", 32'(got), 1);
    endtask

    task automatic wr(input int addr, input logic [7:0] d);
        logic [7:0] r;
        bus(0, addr, d, r);
    endtask

    task automatic rd_chk(input int addr, input logic [7:0] exp, input string name);
        logic [7:0] r;
        bus(1, addr, 8'h00, r);
        check(name, r, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_val[i] = '0;
            for (int j = 0; j < 4; j++) m_hist[i][j] = 0;
        end
        m_mask = '0; m_thresh = '0; m_line = '0;
    endtask

    task automatic model_snapshot(input logic [7:0] msk);
        for (int i = 0; i < 8; i++) begin
            if (msk[i]) begin
                int raw = (dly[i] >= 255) ? 255 : dly[i];
`ifdef QTR_AVG_EN
                for (int j = 3; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
                m_hist[i][0] = raw;
                m_val[i] = 8'((m_hist[i][0] + m_hist[i][1] + m_hist[i][2] + m_hist[i][3]) / 4);
`else
                m_val[i] = 8'(raw);
`endif
            end
            m_line[i] = (m_val[i] >= m_thresh);
        end
    endtask

    task automatic do_scan(input logic [7:0] msk, input logic [7:0] thr, input bit dbl);
        bit ok;
        int maxd = 0, s0;
        qin = '1;
        wr(1, msk); wr(3, thr);
        m_mask = msk; m_thresh = thr;
        s0 = n_starts;
        wr(0, 8'h06);
        if (dbl) wr(0, 8'h06);
        ok = 0;
        for (int c = 0; c < 200; c++) begin @(negedge clk); if (oen != 0) begin ok = 1; break; end end
        check("charge_seen", 32'(ok), 1);
        ok = 0;
        for (int c = 0; c < 200; c++) begin @(negedge clk); if (oen == 0) begin ok = 1; break; end end
        check("charge_end", 32'(ok), 1);
        // a fall d*T-2 cycles after charge end leaves exactly d ticks once the 2-flop sync is counted
        for (int i = 0; i < 8; i++) if (msk[i] && dly[i] < 255 && dly[i]*T-2 > maxd) maxd = dly[i]*T-2;
        for (int k = 1; k <= maxd; k++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) if (msk[i] && dly[i] < 255 && k == dly[i]*T-2) qin[i] = 1'b0;
        end
        ok = 0;
        for (int c = 0; c < 4000; c++) begin @(negedge clk); if (irq) begin ok = 1; break; end end
        check("scan_irq", 32'(ok), 1);
        model_snapshot(msk);
        rd_chk(4, dbl ? 8'h06 : 8'h02, "status_done");
        check("irq_cleared", 32'(irq), 0);
        check("one_snapshot", 32'(n_starts - s0), 1);
        for (int i = 0; i < 8; i++) rd_chk(8 + i, m_val[i], $sformatf("val%0d", i));
        rd_chk(5, m_line, "line");
    endtask

    task automatic period_test(input logic [7:0] per, input int exp_ivl, input string name);
        int s0;
        bit ok = 0;
        wr(2, per);
        s0 = start_times.size();
        wr(0, 8'h01);
        for (int c = 0; c < 8000; c++) begin @(negedge clk); if (start_times.size() >= s0 + 3) begin ok = 1; break; end end
        wr(0, 8'h00);
        check({name, "_starts"}, 32'(ok), 1);
        if (ok) begin
            for (int j = 0; j < 2; j++) begin
                int ivl = start_times[s0+j+1] - start_times[s0+j];
                check({name, "_ivl"}, 32'(ivl >= exp_ivl - T && ivl <= exp_ivl + T), 1);
            end
        end
        repeat (50) @(negedge clk);
        rd_chk(4, 8'h02, {name, "_status"});
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] r;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // reset register image
        check("reset_oen", oen, 0);
        rd_chk(0, 8'h00, "rst_ctrl");
        rd_chk(1, 8'h00, "rst_mask");
        rd_chk(2, 8'd50, "rst_period");
        rd_chk(3, 8'h00, "rst_thresh");
        rd_chk(4, 8'h00, "rst_status");
        rd_chk(5, 8'h00, "rst_line");
        rd_chk(6, 8'h00, "unmapped");
        for (int i = 0; i < 8; i++) rd_chk(8 + i, 8'h00, $sformatf("rst_val%0d", i));

        // another peripheral's address must not be acknowledged
        @(negedge clk); sel = 1'b1; rnw = 1'b0; abus = 12'h101; dbus = 8'hFF;
        repeat (3) begin @(negedge clk); check("foreign_noack", 32'(ack), 0); end
        sel = 1'b0;
        rd_chk(1, 8'h00, "foreign_ignored");

        // MASK=0 trigger starts nothing
        wr(0, 8'h04);
        repeat (30) @(negedge clk);
        rd_chk(4, 8'h00, "mask0_no_scan");
        check("mask0_no_pads", 32'(n_starts), 0);

        // literal scan: ch0 falls after 5 ticks, ch1 saturates
        for (int i = 0; i < 8; i++) dly[i] = 255;
        dly[0] = 5;
        do_scan(8'h03, 8'h20, 0);
`ifndef QTR_AVG_EN
        rd_chk(8, 8'd5, "lit_val0");
        rd_chk(9, 8'd255, "lit_val1");
        rd_chk(5, 8'h02, "lit_line");
`endif

        // randomized scans
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < 8; i++) dly[i] = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(1, 30));
            do_scan(8'($urandom_range(1, 255)), 8'($urandom_range(0, 32)), 0);
        end

        // second trigger while busy
        for (int i = 0; i < 8; i++) dly[i] = int'($urandom_range(1, 20));
        do_scan(8'h81, 8'h08, 1);
        rd_chk(4, 8'h00, "overrun_cleared");

        // periodic scans with inputs already low
        qin = '0;
        wr(1, 8'h01); m_mask = 8'h01;
        period_test(8'd2, 2000, "period2");
        period_test(8'd0, 1000, "period0");

        // reset during charge
        qin = '1;
        wr(1, 8'hFF); m_mask = 8'hFF;
        wr(0, 8'h04);
        begin
            bit ok = 0;
            for (int c = 0; c < 100; c++) begin @(negedge clk); if (oen != 0) begin ok = 1; break; end end
            check("rst_charge_seen", 32'(ok), 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_oen", oen, 0);
        check("async_sig", osig, 0);
        check("async_ctrl", qctrl, 0);
        check("async_irq", 32'(irq), 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_chk(4, 8'h00, "post_rst_status");
        rd_chk(2, 8'd50, "post_rst_period");
        for (int i = 0; i < 8; i++) rd_chk(8 + i, 8'h00, $sformatf("post_rst_val%0d", i));
        repeat (30) @(negedge clk);
        check("post_rst_idle", oen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hba_qtr_array.md
Name: hba_qtr_array

Overview:
HBA bus peripheral that drives an array of NUM_CH Pololu QTR reflectance sensors and measures their discharge times in parallel.
- Each scan charges all enabled channels, times how long each input takes to fall low, and saturates at 2^VALUE_WIDTH-1 ticks.
- Results are latched atomically into a register snapshot.
- Each snapshot also yields a thresholded line bitmap.
- Scans are periodic or software-triggered, with a done interrupt.

Parameters:
- CLK_FREQUENCY, 60_000_000: hba_clk frequency in Hz.
- DBUS_WIDTH, 8: HBA data bus width.
- PERIPH_ADDR_WIDTH, 4: peripheral select address bits.
- REG_ADDR_WIDTH, 8: register address bits.
- ADDR_WIDTH, PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH: total address width.
- PERIPH_ADDR, 0: this peripheral's select address.
- NUM_CH, 8: sensor channel count, 1..8.
- VALUE_WIDTH, 8: measurement width, at most DBUS_WIDTH.
- TICK_US, 10: measurement resolution in microseconds.
- CHARGE_US, 10: capacitor charge time in microseconds.

Ports:
- hba_clk, in, 1: clock.
- hba_reset_n, in, 1: asynchronous active-low reset.
- hba_rnw, in, 1: 1 = read, 0 = write.
- hba_select, in, 1: transfer in progress.
- hba_abus, in, ADDR_WIDTH: address bus.
- hba_dbus, in, DBUS_WIDTH: write data.
- hba_dbus_slave, out, DBUS_WIDTH: read data; 0 when not acking.
- hba_xferack_slave, out, 1: transfer acknowledge; 0 when inactive.
- slave_interrupt, out, 1: scan-done interrupt.
- qtr_out_en, out, NUM_CH: pad output enable (1 = drive).
- qtr_out_sig, out, NUM_CH: pad drive value.
- qtr_in_sig, in, NUM_CH: pad input (asynchronous).
- qtr_ctrl, out, NUM_CH: emitter enable per channel.

Behaviour:
- Registers (reg address = low REG_ADDR_WIDTH bits):
  - 0 CTRL (rw): b0 run (periodic), b1 intr_en, b2 trigger (write 1 starts one scan; autoclears, reads 0).
  - 1 MASK (rw): channel enables; bits at or above NUM_CH read 0.
  - 2 PERIOD (rw): scan period in 1 ms units; 0 is treated as 1.
  - 3 THRESH (rw): line threshold.
  - 4 STATUS (ro): b0 busy, b1 done, b2 overrun. Reading STATUS clears done and overrun, and deasserts slave_interrupt.
  - 5 LINE (ro): bit i = (VAL[i] >= THRESH).
  - 8+i VAL[i] (ro): snapshot value for i < NUM_CH.
  - Any other address reads 0; writes to ro/unmapped addresses are acked and ignored.
- Bus protocol:
  - The transfer is ours when hba_select=1 and hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH]==PERIPH_ADDR.
  - hba_xferack_slave pulses for exactly 1 cycle, in the cycle after the first matching select cycle. It does not repeat while select stays high.
  - Read data is valid only during ack.
  - Writes take effect at ack.
- Timebase:
  - Prescaler produces a 1-cycle tick every CLK_FREQUENCY*TICK_US/1e6 cycles.
  - A ms counter produces a sync pulse every PERIOD ms while run=1.
  - The ms counter restarts from 0 when run goes 0->1.
- Input sync: qtr_in_sig passes through a 2-flop synchroniser per channel before use.
- Channel FSM (per channel, one instance each):
  - IDLE: out_en=0, ctrl=0.
  - start -> CHARGE: out_en=1, out_sig=1, ctrl=1, held for CHARGE_US.
  - -> MEASURE: out_en=0, ctrl=1, count=0; count increments on each tick.
  - Exits MEASURE when the synced input is 0 (value=count), or when count reaches max (value=max, saturated).
  - -> DONE: ctrl=0, holds value until the controller acks, then returns to IDLE.
- Scan controller:
  - sync or trigger with MASK!=0 and not busy: pulse start to all channels in MASK; busy=1.
  - When every enabled channel is in DONE, in one cycle:
    - copy those channel values into VAL; disabled channels keep their old VAL;
    - recompute LINE;
    - set done=1 and busy=0;
    - release the channels.
  - sync/trigger while busy: ignored, overrun=1.
  - MASK==0: no scan starts; trigger is cleared.
  - A MASK write during a scan takes effect at the next scan.
- slave_interrupt = done & intr_en (level output).
- Simultaneous events: a STATUS-read clear and a new done in the same cycle leave done=1.
- Reset (asynchronous, any time):
  - all FSMs go to IDLE;
  - qtr_out_en=0, qtr_out_sig=0, qtr_ctrl=0;
  - all registers 0, except PERIOD=50;
  - hba_xferack_slave=0, hba_dbus_slave=0, slave_interrupt=0.
  - Reset during CHARGE releases the pads immediately.

Optional Feature:
QTR_AVG_EN
- Defined: each channel keeps a 4-deep history of snapshot values, and VAL[i] is their sum >> 2 (VALUE_WIDTH+2-bit accumulator). The history is reset to 0. LINE uses the averaged value.
- Undefined: VAL[i] is the raw latest measurement, and no history storage is built.

Decomposition:
- Package hba_qtr_array_pkg:
  - channel state enum (IDLE, CHARGE, MEASURE, DONE);
  - register address constants;
  - CTRL/STATUS bit index constants;
  - PERIOD reset value 50.
- Sub-module qtr_chan: one channel FSM plus its synchroniser. Inputs are start, ack and tick; outputs are done, value and the three pad signals.

Test Plan:
- Reset, then read every register -> PERIOD=50, all others 0, and qtr_out_en=0.
- Trigger with MASK=0x03 and THRESH=0x20; ch0 input falls 5 ticks after charge ends, ch1 never falls -> VAL0=5, VAL1=255, LINE=0x02, done=1.
- Set intr_en, trigger a scan -> slave_interrupt=1 when done. Read STATUS -> reads 0x02 and interrupt drops on the next cycle.
- Trigger, then trigger again while busy -> second trigger ignored, STATUS overrun bit=1, exactly one snapshot taken.
- run=1 with PERIOD=2 -> scans start 2 ms apart (±1 tick). PERIOD=0 -> scans start 1 ms apart.
- Assert hba_reset_n low during CHARGE -> qtr_out_en=0 asynchronously. After release, busy=0 and VAL is unchanged from 0.
